// File: rtl/vga_timing.sv
// vga_timing: raster counters, active-video window and sync pulses for a 640x480 display.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync by two clk_0 cycles to line up with the renderer's registered RGB path.
module vga_timing #(
    parameter int h_video = 640,
    parameter int h_front = 16,
    parameter int h_sync  = 96,
    parameter int h_back  = 48,
    parameter int v_video = 480,
    parameter int v_front = 10,
    parameter int v_sync  = 2,
    parameter int v_back  = 33
) (
    input  logic       clk_0,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       line_start
);
    localparam int H_TOTAL = h_video + h_front + h_sync + h_back;
    localparam int V_TOTAL = v_video + v_front + v_sync + v_back;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(h_video);
    localparam logic [9:0] V_ACT  = 10'(v_video);
    localparam logic [9:0] HS_BEG = 10'(h_video + h_front);
    localparam logic [9:0] HS_END = 10'(h_video + h_front + h_sync);
    localparam logic [9:0] VS_BEG = 10'(v_video + v_front);
    localparam logic [9:0] VS_END = 10'(v_video + v_front + v_sync);

    logic [9:0] h_cnt, v_cnt;
    logic       h_last, v_last;
    logic       hs_raw, vs_raw;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end
    end

    // Gating by rst keeps every output idle for the whole reset window, not only after its first edge.
    assign pixel_x     = rst ? h_cnt : '0;
    assign pixel_y     = rst ? v_cnt : '0;
    assign video_on    = rst & (h_cnt < H_ACT) & (v_cnt < V_ACT);
    assign line_start  = rst & (h_cnt == '0);
    assign frame_start = rst & (h_cnt == '0) & (v_cnt == '0);

    assign hs_raw = ~((h_cnt >= HS_BEG) & (h_cnt < HS_END));
    assign vs_raw = ~((v_cnt >= VS_BEG) & (v_cnt < VS_END));

`ifdef VGA_SYNC_ALIGN_EN
    logic [1:0] hs_pipe, vs_pipe;

    // Pipes reset to the idle level so no stale pulse escapes after release.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            hs_pipe <= {hs_pipe[0], hs_raw};
            vs_pipe <= {vs_pipe[0], vs_raw};
        end
    end

    assign hsync = ~rst | hs_pipe[1];
    assign vsync = ~rst | vs_pipe[1];
`else
    assign hsync = ~rst | hs_raw;
    assign vsync = ~rst | vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing and reset, reduced-size instance for frame timing.
module tb_vga_timing;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       ls;
    } out_t;

    typedef struct {
        int   t;
        out_t e;
    } vec_t;

    logic clk_0 = 1'b0;
    logic rst_a, rst_b;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic von_a, hs_a, vs_a, fs_a, ls_a;
    logic von_b, hs_b, vs_b, fs_b, ls_b;
    out_t oa, ob;

    int total = 0;
    int bad   = 0;

    always #5 clk_0 = ~clk_0;

    vga_timing u_a (
        .clk_0(clk_0), .rst(rst_a), .pixel_x(px_a), .pixel_y(py_a), .video_on(von_a),
        .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .line_start(ls_a)
    );

    // 16 x 13 raster: hsync low at x 10..12, vsync low on lines 8..9, frame of 208 cycles
    vga_timing #(
        .h_video(8), .h_front(2), .h_sync(3), .h_back(3),
        .v_video(6), .v_front(2), .v_sync(2), .v_back(3)
    ) u_b (
        .clk_0(clk_0), .rst(rst_b), .pixel_x(px_b), .pixel_y(py_b), .video_on(von_b),
        .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b), .line_start(ls_b)
    );

    assign oa = {px_a, py_a, von_a, hs_a, vs_a, fs_a, ls_a};
    assign ob = {px_b, py_b, von_b, hs_b, vs_b, fs_b, ls_b};

    task automatic step();
        @(posedge clk_0);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t a, input out_t e);
        chk({tag, ".pixel_x"},     int'(a.px),  int'(e.px));
        chk({tag, ".pixel_y"},     int'(a.py),  int'(e.py));
        chk({tag, ".video_on"},    int'(a.von), int'(e.von));
        chk({tag, ".hsync"},       int'(a.hs),  int'(e.hs));
        chk({tag, ".vsync"},       int'(a.vs),  int'(e.vs));
        chk({tag, ".frame_start"}, int'(a.fs),  int'(e.fs));
        chk({tag, ".line_start"},  int'(a.ls),  int'(e.ls));
    endtask

    function automatic vec_t mk(input int t, input int px, input int py, input bit von,
                                input bit hs, input bit vs, input bit fs, input bit ls);
        vec_t r;
        r.t     = t;
        r.e.px  = 10'(px);
        r.e.py  = 10'(py);
        r.e.von = von;
        r.e.hs  = hs;
        r.e.vs  = vs;
        r.e.fs  = fs;
        r.e.ls  = ls;
        return r;
    endfunction

    initial begin
        vec_t tbl[12];
        out_t rv;
        int cur, hs_low, hs_first, ls_n, von_n, vs_low, vs_first, fs_n, fs_prev, fs_gap, von_late;

        // t = cycles since release; x = t % 800, y = t / 800
        tbl[0]  = mk(0,        0,        0, 1, 1, 1, 1, 1);
        tbl[1]  = mk(1,        1,        0, 1, 1, 1, 0, 0);
        tbl[2]  = mk(639,      639,      0, 1, 1, 1, 0, 0);
        tbl[3]  = mk(640,      640,      0, 0, 1, 1, 0, 0);
        tbl[4]  = mk(655 + SD, 655 + SD, 0, 0, 1, 1, 0, 0);
        tbl[5]  = mk(656 + SD, 656 + SD, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(751 + SD, 751 + SD, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(752 + SD, 752 + SD, 0, 0, 1, 1, 0, 0);
        tbl[8]  = mk(799,      799,      0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(800,      0,        1, 1, 1, 1, 0, 1);
        tbl[10] = mk(801,      1,        1, 1, 1, 1, 0, 0);
        tbl[11] = mk(1600,     0,        2, 1, 1, 1, 0, 1);
        rv = mk(0, 0, 0, 0, 1, 1, 0, 0).e;

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) step();
        chk_out("a_reset", oa, rv);
        chk_out("b_reset", ob, rv);

        // full-size instance: release, then table walk through the first lines
        rst_a = 1'b1;
        #1;
        cur = 0;
        for (int k = 0; k < 12; k++) begin
            while (cur < tbl[k].t) begin
                step();
                cur++;
            end
            chk_out($sformatf("a_vec%0d", k), oa, tbl[k].e);
        end

        // line 2 in full
        hs_low = 0; hs_first = -1; ls_n = 0; von_n = 0;
        for (int i = 0; i < 800; i++) begin
            if (!oa.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (oa.ls)  ls_n++;
            if (oa.von) von_n++;
            step();
            cur++;
        end
        chk("a_hsync_low_cycles", hs_low, 96);
        chk("a_hsync_first_low_x", hs_first, 656 + SD);
        chk("a_line_start_per_line", ls_n, 1);
        chk("a_video_on_per_line", von_n, 640);

        // mid-frame reset at (300,3)
        while (cur < 2700) begin
            step();
            cur++;
        end
        chk("a_pre_reset_x", int'(oa.px), 300);
        chk("a_pre_reset_y", int'(oa.py), 3);
        rst_a = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("a_midreset%0d", i), oa, rv);
            step();
        end
        rst_a = 1'b1;
        #1;
        chk_out("a_rerelease", oa, mk(0, 0, 0, 1, 1, 1, 1, 1).e);
        step();
        step();
        chk_out("a_rerelease_t2", oa, mk(0, 2, 0, 1, 1, 1, 0, 0).e);

        // reduced instance: two frames
        rst_b = 1'b1;
        #1;
        chk_out("b_release", ob, mk(0, 0, 0, 1, 1, 1, 1, 1).e);
        vs_low = 0; vs_first = -1; von_n = 0; von_late = 0; ls_n = 0;
        fs_n = 0; fs_prev = -1; fs_gap = -1;
        for (int i = 0; i < 416; i++) begin
            if (ob.fs) begin
                if (fs_prev >= 0) fs_gap = i - fs_prev;
                fs_prev = i;
                fs_n++;
            end
            if (i < 208) begin
                if (!ob.vs) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = i;
                end
                if (ob.von) von_n++;
                if (ob.von && (i / 16) >= 6) von_late++;
                if (ob.ls) ls_n++;
            end
            if (i == 207) chk_out("b_last_pixel", ob, mk(0, 15, 12, 0, 1, 1, 0, 0).e);
            if (i == 208) chk_out("b_wrap", ob, mk(0, 0, 0, 1, 1, 1, 1, 1).e);
            step();
        end
        chk("b_frame_start_count", fs_n, 2);
        chk("b_frame_period", fs_gap, 208);
        chk("b_vsync_low_cycles", vs_low, 32);
        chk("b_vsync_first_low_t", vs_first, 128 + SD);
        chk("b_video_on_cycles", von_n, 48);
        chk("b_video_on_blank_lines", von_late, 0);
        chk("b_line_starts", ls_n, 13);

        // reset while both syncs are low at (12,8): nothing partial after release
        repeat (140) step();
        chk_out("b_in_sync", ob, mk(0, 12, 8, 0, 0, 0, 0, 0).e);
        rst_b = 1'b0;
        #1;
        chk_out("b_midreset", ob, rv);
        repeat (3) step();
        chk_out("b_midreset_held", ob, rv);
        rst_b = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_post_x%0d", i), int'(ob.px), i);
            chk($sformatf("b_post_hs%0d", i), int'(ob.hs), 1);
            chk($sformatf("b_post_vs%0d", i), int'(ob.vs), 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL provide parameter h_video, 640, horizontal active pixels.
REQ-002 SHALL provide parameter h_front, 16, horizontal front porch in pixels.
REQ-003 SHALL provide parameter h_sync, 96, horizontal sync pulse width in pixels.
REQ-004 SHALL provide parameter h_back, 48, horizontal back porch in pixels.
REQ-005 SHALL provide parameter v_video, 480, vertical active lines.
REQ-006 SHALL provide parameter v_front, 10, vertical front porch in lines.
REQ-007 SHALL provide parameter v_sync, 2, vertical sync pulse width in lines.
REQ-008 SHALL provide parameter v_back, 33, vertical back porch in lines.
REQ-009 SHALL provide port clk_0  input  1  25 MHz pixel clock.
REQ-010 SHALL provide port rst  input  1  reset; synchronous, active-low.
REQ-011 SHALL provide port pixel_x  output  10  current horizontal count.
REQ-012 SHALL provide port pixel_y  output  10  current vertical count.
REQ-013 SHALL provide port video_on  output  1  high inside the active region.
REQ-014 SHALL provide port hsync  output  1  horizontal sync to connector, active-low.
REQ-015 SHALL provide port vsync  output  1  vertical sync to connector, active-low.
REQ-016 SHALL provide port frame_start  output  1  one-cycle pulse at pixel (0,0).
REQ-017 SHALL provide port line_start  output  1  one-cycle pulse at pixel_x==0 on every line.

Function
REQ-018 SHALL define H_TOTAL = h_video+h_front+h_sync+h_back (800) and V_TOTAL = v_video+v_front+v_sync+v_back (525).
REQ-019 SHALL increment the horizontal counter every clk_0 cycle, 0..H_TOTAL-1, wrapping 799->0.
REQ-020 SHALL increment the vertical counter only in the cycle where the horizontal counter wraps, 0..V_TOTAL-1, wrapping 524->0 on the same edge where the horizontal count wraps.
REQ-021 SHALL drive pixel_x and pixel_y directly from the counter registers, with zero added latency.
REQ-022 SHALL assert video_on iff pixel_x < h_video and pixel_y < v_video, in the same cycle as the matching counts.
REQ-023 SHALL drive hsync low iff h_video+h_front <= pixel_x < h_video+h_front+h_sync (656..751), otherwise high.
REQ-024 SHALL drive vsync low iff v_video+v_front <= pixel_y < v_video+v_front+v_sync (490..491) for all 800 cycles of those lines, otherwise high.
REQ-025 SHALL assert frame_start for exactly one cycle when pixel_x==0 and pixel_y==0.
REQ-026 SHALL assert line_start for exactly one cycle when pixel_x==0 on every line, including line 0.
REQ-027 SHALL produce a frame period of exactly 420000 clk_0 cycles.

Reset
REQ-028 SHALL, while rst==0 at a clk_0 edge, load both counters with 0.
REQ-029 SHALL hold video_on=0, hsync=1, vsync=1, frame_start=0, line_start=0, pixel_x=0 and pixel_y=0 while rst==0.
REQ-030 SHALL, on the first edge after rst returns high, start counting from (0,0) with frame_start asserted in that first cycle.
REQ-031 SHALL return to (0,0) when reset is asserted mid-frame, with no partial sync pulse after release.

Configuration
REQ-032 SHALL, when macro VGA_SYNC_ALIGN_EN is defined, delay hsync and vsync by exactly 2 clk_0 cycles through registers reset to 1, to match the two-stage registered RGB path of the renderer.
REQ-033 SHALL, when VGA_SYNC_ALIGN_EN is undefined, drive hsync and vsync with zero delay per REQ-023/024; pixel_x, pixel_y, video_on, frame_start and line_start are never delayed in either build.

Verification
REQ-034 SHALL verify: release reset -> frame_start=1, line_start=1, pixel_x=0, pixel_y=0, video_on=1 in the first cycle.
REQ-035 SHALL verify: count from (0,0) -> video_on falls at pixel_x=640; hsync low for pixel_x 656..751 (96 cycles); line_start recurs every 800 cycles.
REQ-036 SHALL verify: pixel_x 799, pixel_y 524 -> next cycle (0,0), frame_start=1; frame_start spacing exactly 420000 cycles.
REQ-037 SHALL verify: lines 490 and 491 -> vsync low for exactly 1600 cycles; video_on=0 for all of lines 480..524.
REQ-038 SHALL verify: rst=0 at (300,200) for 5 cycles -> outputs at reset values throughout; resumes at (0,0) after release.
REQ-039 SHALL verify: with VGA_SYNC_ALIGN_EN defined -> hsync falls 2 cycles after pixel_x=656 and rises 2 cycles after pixel_x=752.
